// File: rtl/usbh_pkg.sv
// Shared definitions for the two-port HID report arbiter: the released
// (neutral) report, report field positions and the arbiter FSM encoding.
package usbh_pkg;

  // Released report: hat centred (4'hF), all four axes centred (8'h80), no buttons.
  localparam logic [63:0] c_neutral_report = 64'hF000_0080_8080_8000;

  // Report field positions.
  localparam int unsigned c_hat_msb   = 63;
  localparam int unsigned c_hat_lsb   = 60;
  localparam int unsigned c_axis0_msb = 39;
  localparam int unsigned c_axis1_msb = 31;
  localparam int unsigned c_axis2_msb = 23;
  localparam int unsigned c_axis3_msb = 15;

  // Arbiter sequencing: grant in IDLE, hold the report in SETUP, strobe in STROBE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2
  } usbh_state_e;

  // True when the report shows a centred hat and centred axes (a released stick).
  function automatic logic report_is_released(input logic [63:0] rep);
    logic released;
    released = (rep[c_hat_msb:c_hat_lsb] == 4'hF) &&
               rep[c_axis0_msb] && rep[c_axis1_msb] &&
               rep[c_axis2_msb] && rep[c_axis3_msb];
    return released;
  endfunction

endpackage

// File: rtl/usbh_port_watchdog.sv
// Per-port silence watchdog. Counts cycles since the last report strobe,
// saturates at the terminal count, emits a single expire pulse per silence
// episode and holds the timeout level until the next real report.
module usbh_port_watchdog #(
  parameter int unsigned c_terminal = 12
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_valid,
  output logic o_expire,
  output logic o_timeout
);

  localparam int unsigned c_cnt_w = (c_terminal > 32'd1) ? $clog2(c_terminal) : 1;
  // Last representable count value; the expire fires while sitting on it.
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_terminal - 32'd1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;
  logic               timeout_q;
  logic               timeout_d;
  logic               expire_s;

  // Next-state: a real report always wins over a simultaneous expiry.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    expire_s  = 1'b0;
    if (i_valid) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (cnt_q == c_last) begin
      if (!timeout_q) begin
        expire_s  = 1'b1;
        timeout_d = 1'b1;
      end else begin
        expire_s  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and timeout flag registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_expire  = expire_s;
  assign o_timeout = timeout_q;

endmodule

// File: rtl/usbh_report_arbiter.sv
// Shares one HID report decoder between two USB host ports. Each port's
// report lands in a one-deep buffer; the decoder is granted round-robin and
// each granted report is held stable for c_setup cycles before a one-cycle
// latch strobe. Silent ports get a neutral report injected by a watchdog.
module usbh_report_arbiter
  import usbh_pkg::*;
#(
  parameter int unsigned c_clk_hz     = 6000000,
  parameter int unsigned c_timeout_ms = 100,
  parameter int unsigned c_setup      = 2,
  parameter logic [63:0] c_neutral    = c_neutral_report
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [63:0] i_report0,
  input  logic        i_report0_valid,
  input  logic [63:0] i_report1,
  input  logic        i_report1_valid,
  output logic [63:0] o_report,
  output logic        o_report_valid,
  output logic        o_port,
  output logic [1:0]  o_timeout,
  output logic [1:0]  o_overrun
);

  localparam int unsigned c_wd_terminal = (c_clk_hz / 32'd1000) * c_timeout_ms;
  localparam int unsigned c_cnt_w       = (c_setup > 32'd1) ? $clog2(c_setup) : 1;
  localparam logic [c_cnt_w-1:0] c_setup_init = c_cnt_w'(c_setup - 32'd1);

  // Capture side
  logic [1:0][63:0] report_in_s;
  logic [1:0]       valid_in_s;
  logic [1:0]       expire_s;
  logic [1:0][63:0] buf_q;
  logic [1:0][63:0] buf_d;
  logic [1:0]       pend_q;
  logic [1:0]       pend_d;
  logic [1:0]       ovr_q;
  logic [1:0]       ovr_d;

  // Grant / presentation side
  usbh_state_e      state_q;
  usbh_state_e      state_d;
  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;
  logic             rr_q;
  logic             rr_d;
  logic [63:0]      rep_q;
  logic [63:0]      rep_d;
  logic             port_q;
  logic             port_d;
  logic             strobe_q;
  logic             strobe_d;
  logic             grant_s;
  logic             gnt_port_s;
  logic [1:0]       grant_vec_s;

  assign report_in_s = {i_report1, i_report0};
  assign valid_in_s  = {i_report1_valid, i_report0_valid};

  usbh_port_watchdog #(
    .c_terminal (c_wd_terminal)
  ) u_wd0 (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_valid   (i_report0_valid),
    .o_expire  (expire_s[0]),
    .o_timeout (o_timeout[0])
  );

  usbh_port_watchdog #(
    .c_terminal (c_wd_terminal)
  ) u_wd1 (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_valid   (i_report1_valid),
    .o_expire  (expire_s[1]),
    .o_timeout (o_timeout[1])
  );

  // Grant decision: only in IDLE; on contention the port not served last wins.
  always_comb begin
    grant_s    = (state_q == ST_IDLE) && (pend_q != 2'b00);
    gnt_port_s = 1'b0;
    if (pend_q == 2'b11) begin
      gnt_port_s = rr_q;
    end else begin
      gnt_port_s = pend_q[1];
    end
    if (grant_s) begin
      grant_vec_s = gnt_port_s ? 2'b10 : 2'b01;
    end else begin
      grant_vec_s = 2'b00;
    end
  end

  // Buffer capture: newest report wins; a granted port re-arms pend on a new capture.
  always_comb begin
    buf_d  = buf_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int n = 0; n < 2; n++) begin
      if (grant_vec_s[n]) begin
        pend_d[n] = 1'b0;
      end else begin
        pend_d[n] = pend_q[n];
      end
      if (valid_in_s[n]) begin
        buf_d[n]  = report_in_s[n];
        pend_d[n] = 1'b1;
        if (pend_q[n] && !grant_vec_s[n]) begin
          ovr_d[n] = 1'b1;
        end else begin
          ovr_d[n] = ovr_q[n];
        end
      end else if (expire_s[n]) begin
        buf_d[n]  = c_neutral;
        pend_d[n] = 1'b1;
        if (pend_q[n] && !grant_vec_s[n]) begin
          ovr_d[n] = 1'b1;
        end else begin
          ovr_d[n] = ovr_q[n];
        end
      end else begin
        buf_d[n] = buf_q[n];
      end
    end
  end

  // Presentation FSM: grant loads the report, SETUP holds it, STROBE fires the latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    port_d   = port_q;
    rr_d     = rr_q;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          rep_d  = buf_q[gnt_port_s];
          port_d = gnt_port_s;
          cnt_d  = c_setup_init;
          if (c_setup == 32'd1) begin
            state_d = ST_STROBE;
          end else begin
            state_d = ST_SETUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= c_cnt_w'(1)) begin
          state_d = ST_STROBE;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_STROBE: begin
        strobe_d = 1'b1;
        rr_d     = ~port_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, buffers and output registers; reset returns the neutral report.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      buf_q    <= {c_neutral, c_neutral};
      pend_q   <= 2'b00;
      ovr_q    <= 2'b00;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      rep_q    <= c_neutral;
      port_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rep_q    <= rep_d;
      port_q   <= port_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_report       = rep_q;
  assign o_report_valid = strobe_q;
  assign o_port         = port_q;
  assign o_overrun      = ovr_q;

endmodule

// File: tb/tb_usbh_report_arbiter.sv
// Directed bench for usbh_report_arbiter: a cycle-by-cycle vector table for
// single, contended, overrun and grant/capture-collision traffic, plus
// hand-written sequences for mid-transaction reset and watchdog injection.
module tb_usbh_report_arbiter;

  localparam logic [63:0] NEU = 64'hF000_0080_8080_8000;
  localparam logic [63:0] RA  = 64'h0100_0000_0000_0000;
  localparam logic [63:0] RB  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RC  = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] RD  = 64'hDDDD_0000_DDDD_0001;
  localparam logic [63:0] RE1 = 64'hE100_0000_0000_00E1;
  localparam logic [63:0] RE2 = 64'hE200_0000_0000_00E2;
  localparam logic [63:0] RE3 = 64'hE300_0000_0000_00E3;
  localparam logic [63:0] RG  = 64'h6666_7777_8888_9999;
  localparam logic [63:0] RH  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] RJ  = 64'hCAFE_0000_BEEF_0000;
  localparam logic [63:0] RK  = 64'h0000_FACE_0000_F00D;
  localparam logic [63:0] RX  = 64'h2468_ACE0_1357_9BDF;

  logic        clk;
  logic        rstn;
  logic [63:0] in_r0, in_r1;
  logic        in_v0, in_v1;
  logic [63:0] out_rep;
  logic        out_rv, out_port;
  logic [1:0]  out_tmo, out_ovr;

  logic        wd_rstn;
  logic [63:0] wd_r0, wd_r1;
  logic        wd_v0, wd_v1;
  logic [63:0] wd_rep;
  logic        wd_rv, wd_port;
  logic [1:0]  wd_tmo, wd_ovr;

  int checks = 0;
  int errors = 0;

  usbh_report_arbiter #(
    .c_clk_hz (6000), .c_timeout_ms (100), .c_setup (2), .c_neutral (NEU)
  ) dut (
    .i_clk (clk), .i_rstn (rstn),
    .i_report0 (in_r0), .i_report0_valid (in_v0),
    .i_report1 (in_r1), .i_report1_valid (in_v1),
    .o_report (out_rep), .o_report_valid (out_rv), .o_port (out_port),
    .o_timeout (out_tmo), .o_overrun (out_ovr)
  );

  usbh_report_arbiter #(
    .c_clk_hz (6000), .c_timeout_ms (2), .c_setup (2), .c_neutral (NEU)
  ) dut_wd (
    .i_clk (clk), .i_rstn (wd_rstn),
    .i_report0 (wd_r0), .i_report0_valid (wd_v0),
    .i_report1 (wd_r1), .i_report1_valid (wd_v1),
    .o_report (wd_rep), .o_report_valid (wd_rv), .o_port (wd_port),
    .o_timeout (wd_tmo), .o_overrun (wd_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [63:0] r0;
    logic        v1;
    logic [63:0] r1;
    logic        e_valid;
    logic        e_port;
    logic [63:0] e_rep;
    logic [1:0]  e_ovr;
  } vec_t;

  vec_t vecs [29];

  function automatic vec_t mk(input logic a_v0, input logic [63:0] a_r0,
                              input logic a_v1, input logic [63:0] a_r1,
                              input logic a_ev, input logic a_ep,
                              input logic [63:0] a_er, input logic [1:0] a_eo);
    vec_t v;
    v.v0 = a_v0; v.r0 = a_r0; v.v1 = a_v1; v.r1 = a_r1;
    v.e_valid = a_ev; v.e_port = a_ep; v.e_rep = a_er; v.e_ovr = a_eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int strobes;
    int s0, s1;
    int bad_tmo;
    bit found;

    // Single report (0-4), contention after port 0 served (5-12),
    // overrun during a port 1 transaction (13-20), capture colliding with grant (21-28).
    vecs[0]  = mk(1'b1, RA,  1'b0, 64'd0, 1'b0, 1'b0, NEU, 2'b00);
    vecs[1]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RA,  2'b00);
    vecs[2]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RA,  2'b00);
    vecs[3]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, RA,  2'b00);
    vecs[4]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RA,  2'b00);
    vecs[5]  = mk(1'b1, RB,  1'b1, RC,  1'b0, 1'b0, RA,  2'b00);
    vecs[6]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, RC,  2'b00);
    vecs[7]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, RC,  2'b00);
    vecs[8]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, RC,  2'b00);
    vecs[9]  = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RB,  2'b00);
    vecs[10] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RB,  2'b00);
    vecs[11] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, RB,  2'b00);
    vecs[12] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RB,  2'b00);
    vecs[13] = mk(1'b0, 64'd0, 1'b1, RD,  1'b0, 1'b0, RB,  2'b00);
    vecs[14] = mk(1'b1, RE1, 1'b0, 64'd0, 1'b0, 1'b1, RD,  2'b00);
    vecs[15] = mk(1'b1, RE2, 1'b0, 64'd0, 1'b0, 1'b1, RD,  2'b01);
    vecs[16] = mk(1'b1, RE3, 1'b0, 64'd0, 1'b1, 1'b1, RD,  2'b01);
    vecs[17] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RE3, 2'b01);
    vecs[18] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RE3, 2'b01);
    vecs[19] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, RE3, 2'b01);
    vecs[20] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, RE3, 2'b01);
    vecs[21] = mk(1'b0, 64'd0, 1'b1, RG,  1'b0, 1'b0, RE3, 2'b01);
    vecs[22] = mk(1'b0, 64'd0, 1'b1, RH,  1'b0, 1'b1, RG,  2'b01);
    vecs[23] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, RG,  2'b01);
    vecs[24] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, RG,  2'b01);
    vecs[25] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, RH,  2'b01);
    vecs[26] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, RH,  2'b01);
    vecs[27] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, RH,  2'b01);
    vecs[28] = mk(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, RH,  2'b01);

    clk = 1'b0; rstn = 1'b0; wd_rstn = 1'b0;
    in_r0 = 64'd0; in_r1 = 64'd0; in_v0 = 1'b0; in_v1 = 1'b0;
    wd_r0 = 64'd0; wd_r1 = 64'd0; wd_v0 = 1'b0; wd_v1 = 1'b0;

    // Reset values while held
    #22;
    chk("rst.report", out_rep, NEU);
    chk("rst.valid", 64'(out_rv), 64'd0);
    chk("rst.port", 64'(out_port), 64'd0);
    chk("rst.timeout", 64'(out_tmo), 64'd0);
    chk("rst.overrun", 64'(out_ovr), 64'd0);

    @(negedge clk) rstn = 1'b1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_rv) strobes++;
    end
    chk("idle.no_strobe", 64'(strobes), 64'd0);

    // Table-driven cycles: drive, clock, compare just after the edge
    for (int i = 0; i < 29; i++) begin
      in_v0 = vecs[i].v0; in_r0 = vecs[i].r0;
      in_v1 = vecs[i].v1; in_r1 = vecs[i].r1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.valid", i), 64'(out_rv), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.port", i), 64'(out_port), 64'(vecs[i].e_port));
      chk($sformatf("vec%0d.report", i), out_rep, vecs[i].e_rep);
      chk($sformatf("vec%0d.overrun", i), 64'(out_ovr), 64'(vecs[i].e_ovr));
      chk($sformatf("vec%0d.timeout", i), 64'(out_tmo), 64'd0);
    end
    in_v0 = 1'b0; in_v1 = 1'b0;

    // Mid-transaction reset: both ports pending, reset during port 0 SETUP
    in_v0 = 1'b1; in_r0 = RJ; in_v1 = 1'b1; in_r1 = RK;
    @(posedge clk); #1;
    in_v0 = 1'b0; in_v1 = 1'b0;
    @(posedge clk); #1;
    chk("midrst.granted_report", out_rep, RJ);
    rstn = 1'b0;
    #1;
    chk("midrst.report", out_rep, NEU);
    chk("midrst.valid", 64'(out_rv), 64'd0);
    chk("midrst.port", 64'(out_port), 64'd0);
    chk("midrst.overrun", 64'(out_ovr), 64'd0);
    chk("midrst.timeout", 64'(out_tmo), 64'd0);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_rv) strobes++;
    end
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_rv) strobes++;
    end
    chk("midrst.no_strobe", 64'(strobes), 64'd0);

    // Watchdog: 12-cycle silence interval, no traffic on either port
    @(negedge clk) wd_rstn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    chk("wd.before_expiry", 64'(wd_tmo), 64'd0);
    @(posedge clk); #1;
    chk("wd.expired", 64'(wd_tmo), 64'(2'b11));
    s0 = 0; s1 = 0; bad_tmo = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (wd_tmo !== 2'b11) bad_tmo++;
      if (wd_rv) begin
        if (wd_port) s1++;
        else s0++;
        chk($sformatf("wd.neutral_port%0d", wd_port), wd_rep, NEU);
      end
    end
    chk("wd.port1_strobes", 64'(s1), 64'd1);
    chk("wd.port0_strobes", 64'(s0), 64'd1);
    chk("wd.timeout_held", 64'(bad_tmo), 64'd0);

    wd_v1 = 1'b1; wd_r1 = RX;
    @(posedge clk); #1;
    wd_v1 = 1'b0;
    chk("wd.cleared_port1", 64'(wd_tmo), 64'(2'b01));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (wd_rv) begin
        found = 1'b1;
        chk("wd.real_report", wd_rep, RX);
        chk("wd.real_port", 64'(wd_port), 64'd1);
      end
    end
    chk("wd.real_strobe_seen", 64'(found), 64'd1);
    chk("wd.overrun", 64'(wd_ovr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
